// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, FSM encoding and pending-entry layout
// for the register-file write-port arbiter.
package wb_port_arbiter_pkg;
    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 4;

    typedef enum logic [1:0] {
        ARB_EMPTY = 2'd0,
        ARB_HOLD  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

    // kill=1 means a younger WB write already targeted this dest
    typedef struct packed {
        logic                         kill;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]          data;
    } pend_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundles the WB-stage, MCU and register-file write-port
// signals around the arbiter.
//   master: drives wb_*/mc_valid/mc_dest/mc_data, observes the rest
//   slave : the arbiter side (mc_ready, pipe_stall, rf_*, pend_count out)
interface wb_port_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    import wb_port_arbiter_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                         wb_we;
    logic [REG_FILE_ADDR_LEN-1:0] wb_dest;
    logic [WORD_LEN-1:0]          wb_data;
    logic                         mc_valid;
    logic [REG_FILE_ADDR_LEN-1:0] mc_dest;
    logic [WORD_LEN-1:0]          mc_data;
    logic                         mc_ready;
    logic                         pipe_stall;
    logic                         rf_we;
    logic [REG_FILE_ADDR_LEN-1:0] rf_dest;
    logic [WORD_LEN-1:0]          rf_data;
    logic [CW-1:0]                pend_count;

    modport master (
        output wb_we, wb_dest, wb_data, mc_valid, mc_dest, mc_data,
        input  mc_ready, pipe_stall, rf_we, rf_dest, rf_data, pend_count
    );
    modport slave (
        input  wb_we, wb_dest, wb_data, mc_valid, mc_dest, mc_data,
        output mc_ready, pipe_stall, rf_we, rf_dest, rf_data, pend_count
    );
endinterface

// File: rtl/wb_pend_fifo.sv
// wb_pend_fifo: pending-MCU-result FIFO of {kill, dest, data}.
//   clk, rst (async, active-low)
//   i_push/i_push_entry : write an entry at the tail
//   i_pop               : drop the head
//   i_kill_en/i_kill_dest: set the kill bit of every entry whose dest matches
//   o_head, o_count     : head entry and occupancy
module wb_pend_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  pend_entry_t                  i_push_entry,
    input  logic                         i_pop,
    input  logic                         i_kill_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] i_kill_dest,
    output pend_entry_t                  o_head,
    output logic [$clog2(DEPTH):0]       o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pend_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            // Marking empty slots is harmless: a push overwrites the kill bit.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_mem[i].dest == i_kill_dest) r_mem[i].kill <= 1'b1;
                if (i_push && r_wr == PW'(i)) r_mem[i] <= i_push_entry;
            end
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage
// and a multi-cycle unit; WB always wins, MCU results wait in a FIFO.
//   clk, rst (async, active-low)
//   bus (slave): wb_* / mc_* requests in; mc_ready, pipe_stall, rf_*,
//                pend_count out
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 8
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT);

    logic [CW-1:0]                w_count;
    logic [CW-1:0]                w_count_next;
    pend_entry_t                  w_head;
    pend_entry_t                  w_push_entry;
    logic                         w_empty;
    logic                         w_pop;
    logic                         w_bypass;
    logic                         w_push;
    logic                         w_at_max;
    logic [WW-1:0]                r_wait;
    arb_state_t                   r_state;
    arb_state_t                   w_state_next;
    logic                         r_we;
    logic [REG_FILE_ADDR_LEN-1:0] r_dest;
    logic [WORD_LEN-1:0]          r_data;

    assign w_empty      = w_count == '0;
    assign bus.mc_ready = w_count < CW'(FIFO_DEPTH);
    assign w_pop        = !bus.wb_we && !w_empty;
    assign w_bypass     = !bus.wb_we && w_empty && bus.mc_valid;
    assign w_push       = bus.mc_valid && bus.mc_ready && !w_bypass;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    assign w_at_max     = r_wait == WW'(MAX_WAIT - 1);
    // A same-cycle WB write to the same dest is younger, so the entry is dead on arrival
    assign w_push_entry = '{kill: bus.wb_we && bus.wb_dest == bus.mc_dest,
                            dest: bus.mc_dest, data: bus.mc_data};

    wb_pend_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_entry(w_push_entry),
        .i_pop       (w_pop),
        .i_kill_en   (bus.wb_we),
        .i_kill_dest (bus.wb_dest),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
        end else begin
            r_we   <= bus.wb_we || (w_pop && !w_head.kill) || w_bypass;
            r_dest <= bus.wb_we ? bus.wb_dest : w_empty ? bus.mc_dest : w_head.dest;
            r_data <= bus.wb_we ? bus.wb_data : w_empty ? bus.mc_data : w_head.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_wait <= '0;
        else      r_wait <= (w_empty || w_pop) ? '0 : w_at_max ? r_wait : r_wait + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ARB_EMPTY;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_EMPTY: w_state_next = w_push ? ARB_HOLD : ARB_EMPTY;
            ARB_HOLD:  w_state_next = (w_count_next == '0) ? ARB_EMPTY :
                                      ((w_at_max && !w_pop) || w_count_next == CW'(FIFO_DEPTH)) ? ARB_FORCE : ARB_HOLD;
            ARB_FORCE: w_state_next = (w_pop && w_count_next < CW'(FIFO_DEPTH)) ?
                                      ((w_count_next == '0) ? ARB_EMPTY : ARB_HOLD) : ARB_FORCE;
            default:   w_state_next = ARB_EMPTY;
        endcase
    end

    always_comb begin
        bus.pipe_stall = r_state == ARB_FORCE;
    end

    assign bus.rf_we      = r_we;
    assign bus.rf_dest    = r_dest;
    assign bus.rf_data    = r_data;
    assign bus.pend_count = w_count;
endmodule
